pattern_gen: RTL

- Pixel-colour stage directly downstream of the VGA `timing` block.
- Consumes `timing`'s hsync, vsync, blank_n, sync_n, disp_enable, Xpix and Ypix, and produces 8-bit R/G/B to the DAC.
- Re-times the sync/blank strobes so they stay aligned with the colour data.
- Modes: colour bars, checkerboard, bouncing box, frame-counter grey fade; motion and mode change once per frame.

---
 rtl/pattern_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pattern_gen.sv
// Pixel-colour stage behind the VGA timing block: two-stage pipeline producing RGB
// test patterns, with the sync/blank strobes delayed to stay aligned with the colour.
`timescale 1ns/1ps
module pattern_gen #(
  parameter int H_disp    = 640,
  parameter int V_disp    = 480,
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int BOX       = 16,
  parameter int CHK_SHIFT = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           blank_n_in,
  input  logic           sync_n_in,
  input  logic           disp_enable,
  input  logic [X_W-1:0] Xpix,
  input  logic [Y_W-1:0] Ypix,
  input  logic [1:0]     mode,
  output logic           hsync,
  output logic           vsync,
  output logic           blank_n,
  output logic           sync_n,
  output logic [7:0]     r,
  output logic [7:0]     g,
  output logic [7:0]     b
);

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_FADE    = 2'd3
  } mode_t;

  localparam int             BAR_W = H_disp / 8;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_disp - BOX);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_disp - BOX);

  // Frame-rate state, updated only on the frame event
  logic [X_W-1:0] box_x;
  logic [Y_W-1:0] box_y;
  logic           dir_x, dir_y;   // 1 = moving towards larger coordinates
  logic [7:0]     frame_cnt;
  mode_t          cur_mode;

  // Stage-1 registers
  logic           s1_hs, s1_vs, s1_bn, s1_sn, s1_de;
  logic [2:0]     s1_bar;
  logic           s1_chk, s1_box;
  mode_t          s1_mode;
  logic [7:0]     s1_grey;

  logic [2:0]     bar_idx;
  logic           chk_sel, in_box, frame_evt;
  logic [X_W:0]   px, bx, bx_end;
  logic [Y_W:0]   py, by, by_end;
  logic [7:0]     nr, ng, nb;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, Xpix} >= (X_W+1)'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Extra top bit keeps box_x+BOX from wrapping
  assign px     = {1'b0, Xpix};
  assign bx     = {1'b0, box_x};
  assign bx_end = bx + (X_W+1)'(BOX);
  assign py     = {1'b0, Ypix};
  assign by     = {1'b0, box_y};
  assign by_end = by + (Y_W+1)'(BOX);

  assign in_box    = (px >= bx) && (px < bx_end) && (py >= by) && (py < by_end);
  assign chk_sel   = Xpix[CHK_SHIFT] ^ Ypix[CHK_SHIFT];
  assign frame_evt = s1_vs & ~vsync_in;

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
      s1_bn   <= 1'b0;
      s1_sn   <= 1'b1;
      s1_de   <= 1'b0;
      s1_bar  <= '0;
      s1_chk  <= 1'b0;
      s1_box  <= 1'b0;
      s1_mode <= MODE_BARS;
      s1_grey <= '0;
    end else begin
      s1_hs   <= hsync_in;
      s1_vs   <= vsync_in;
      s1_bn   <= blank_n_in;
      s1_sn   <= sync_n_in;
      s1_de   <= disp_enable;
      s1_bar  <= bar_idx;
      s1_chk  <= chk_sel;
      s1_box  <= in_box;
      s1_mode <= cur_mode;
      s1_grey <= frame_cnt;
    end
  end

  // At an edge the box turns round and steps back in the same frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x     <= '0;
      box_y     <= '0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      frame_cnt <= '0;
      cur_mode  <= MODE_BARS;
    end else if (frame_evt) begin
      cur_mode  <= mode_t'(mode);
      frame_cnt <= frame_cnt + 8'd1;
      if (dir_x) begin
        if (box_x == X_MAX) begin
          dir_x <= 1'b0;
          box_x <= box_x - 1'b1;
        end else begin
          box_x <= box_x + 1'b1;
        end
      end else begin
        if (box_x == '0) begin
          dir_x <= 1'b1;
          box_x <= box_x + 1'b1;
        end else begin
          box_x <= box_x - 1'b1;
        end
      end
      if (dir_y) begin
        if (box_y == Y_MAX) begin
          dir_y <= 1'b0;
          box_y <= box_y - 1'b1;
        end else begin
          box_y <= box_y + 1'b1;
        end
      end else begin
        if (box_y == '0) begin
          dir_y <= 1'b1;
          box_y <= box_y + 1'b1;
        end else begin
          box_y <= box_y - 1'b1;
        end
      end
    end
  end

  always_comb begin
    nr = '0;
    ng = '0;
    nb = '0;
    case (s1_mode)
      MODE_BARS: begin
        nr = {8{~s1_bar[1]}};
        ng = {8{~s1_bar[2]}};
        nb = {8{~s1_bar[0]}};
      end
      MODE_CHECKER: begin
        nr = {8{s1_chk}};
        ng = {8{s1_chk}};
        nb = {8{s1_chk}};
      end
      MODE_BOX: begin
        nr = {8{s1_box}};
        ng = {8{s1_box}};
        nb = s1_box ? 8'hFF : 8'h80;
      end
      MODE_FADE: begin
        nr = s1_grey;
        ng = s1_grey;
        nb = s1_grey;
      end
      default: ;
    endcase
    if (!s1_de) begin
      nr = '0;
      ng = '0;
      nb = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      sync_n  <= 1'b1;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      hsync   <= s1_hs;
      vsync   <= s1_vs;
      blank_n <= s1_bn;
      sync_n  <= s1_sn;
      r       <= nr;
      g       <= ng;
      b       <= nb;
    end
  end

endmodule
